toe_cam_alloc: RTL and testbench

Entry allocator for the TOE session CAM. It sits directly downstream of the 16-bit Galois LFSR random source and consumes its word to pick a random victim when the CAM is full. When the CAM is not full it hands out free entries by next-fit scan. It keeps a valid bitmap and occupancy count, accepts entry releases from the CAM lookup/delete path, and answers one allocation request at a time.

---
 rtl/toe_cam_pkg.sv | 13 +
 rtl/toe_cam_alloc.sv | 131 +++++++++++++
 tb/tb_toe_cam_alloc.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/toe_cam_pkg.sv
// Shared definitions for the TOE session CAM: geometry and allocator FSM states.
package toe_cam_pkg;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } state_e;

endpackage

// File: rtl/toe_cam_alloc.sv
// Entry allocator for the TOE session CAM. Hands out free entries by next-fit
// scan, picks a random victim from the LFSR word when the CAM is full, and
// tracks the valid bitmap and occupancy count under concurrent releases.
module toe_cam_alloc
  import toe_cam_pkg::*;
#(
  parameter int unsigned DEPTH = toe_cam_pkg::DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic [15:0]   Rnd,
  input  logic          AllocReq,
  output logic          AllocAck,
  output logic [AW-1:0] AllocIdx,
  output logic          AllocEvict,
  input  logic          FreeValid,
  input  logic [AW-1:0] FreeIdx,
  output logic          FreeErr,
  output logic [AW:0]   Count,
  output logic          Full,
  output logic          Empty
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  state_e           state_q, state_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic [AW-1:0]    nf_q, sp_q, li_q, idx_q;
  logic             le_q, ack_q, evict_q, free_err_q;
  logic             grant, same_idx, set_new, clr_hit, free_err_d;

  // Only the low AW bits of the random word pick a victim.
  if (AW < 16) begin : g_rnd_spare
    logic unused_rnd_hi;
    assign unused_rnd_hi = ^Rnd[15:AW];
  end

  // State register.
  always_ff @(posedge Clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: full CAM jumps straight to GRANT, otherwise scan for a hole.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned and infers a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (AllocReq) state_d = full_q ? GRANT : SCAN;
      SCAN:    if (!valid_q[sp_q]) state_d = GRANT;
      GRANT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/update decode: a set in GRANT beats a release of the same index.
  always_comb begin
    grant      = (state_q == GRANT);
    same_idx   = grant && (FreeIdx == li_q);
    set_new    = grant && !valid_q[li_q];
    clr_hit    = FreeValid && valid_q[FreeIdx] && !same_idx;
    free_err_d = FreeValid && !valid_q[FreeIdx] && !same_idx;
    valid_d    = valid_q;
    if (clr_hit) valid_d[FreeIdx] = 1'b0;
    if (grant)   valid_d[li_q]    = 1'b1;
    count_d    = count_q + (AW+1)'(set_new) - (AW+1)'(clr_hit);
  end

  // Bitmap, occupancy, pointers and registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      // NOTE: the bitmap is flops, not a RAM, so it clears on reset like any other state.
      valid_q    <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      nf_q       <= '0;
      sp_q       <= '0;
      li_q       <= '0;
      le_q       <= 1'b0;
      ack_q      <= 1'b0;
      idx_q      <= '0;
      evict_q    <= 1'b0;
      free_err_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      full_q     <= (count_d == CNT_FULL);
      empty_q    <= (count_d == '0);
      free_err_q <= free_err_d;
      ack_q      <= grant;
      idx_q      <= grant ? li_q : '0;
      evict_q    <= grant && le_q;
      if (grant) nf_q <= li_q + AW'(1);
      unique case (state_q)
        IDLE: begin
          if (AllocReq) begin
            if (full_q) begin
              li_q <= Rnd[AW-1:0];
              le_q <= 1'b1;
            end else begin
              sp_q <= nf_q;
            end
          end
        end
        SCAN: begin
          if (!valid_q[sp_q]) begin
            li_q <= sp_q;
            le_q <= 1'b0;
          end else begin
            sp_q <= sp_q + AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign AllocAck   = ack_q;
  assign AllocIdx   = idx_q;
  assign AllocEvict = evict_q;
  assign FreeErr    = free_err_q;
  assign Count      = count_q;
  assign Full       = full_q;
  assign Empty      = empty_q;

endmodule

// File: tb/tb_toe_cam_alloc.sv
// Self-checking bench for toe_cam_alloc: directed scenarios with literal
// expectations plus randomized traffic against an operation-level model.
module tb_toe_cam_alloc;
  import toe_cam_pkg::*;

  logic          clk;
  logic          rst_n;
  logic [15:0]   rnd;
  logic          alloc_req;
  logic          alloc_ack;
  logic [AW-1:0] alloc_idx;
  logic          alloc_evict;
  logic          free_valid;
  logic [AW-1:0] free_idx;
  logic          free_err;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int n_cmp = 0;
  int n_bad = 0;

  toe_cam_alloc dut (
    .Clk        (clk),
    .Rst_n      (rst_n),
    .Rnd        (rnd),
    .AllocReq   (alloc_req),
    .AllocAck   (alloc_ack),
    .AllocIdx   (alloc_idx),
    .AllocEvict (alloc_evict),
    .FreeValid  (free_valid),
    .FreeIdx    (free_idx),
    .FreeErr    (free_err),
    .Count      (count),
    .Full       (full),
    .Empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (operation level) ----------------
  // mode 0: waiting for a request, 1: searching for a hole, 2: grant commits next edge
  bit mv [DEPTH];
  int m_nf, m_mode, m_cur, m_tgt;
  bit m_tev, m_ack, m_ev, m_err;
  int m_idx;

  function automatic int m_popcnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(mv[i]);
    return n;
  endfunction

  // Predict the effect of the coming rising edge from the inputs now driven.
  task automatic model_advance();
    bit pre [DEPTH];
    int pre_cnt;
    int fi;
    bit gr, same;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
      m_nf = 0; m_mode = 0; m_cur = 0; m_tgt = 0; m_tev = 1'b0;
      m_ack = 1'b0; m_idx = 0; m_ev = 1'b0; m_err = 1'b0;
      return;
    end
    pre     = mv;
    pre_cnt = m_popcnt();
    fi      = int'(free_idx);
    gr      = (m_mode == 2);
    same    = gr && (fi == m_tgt);
    m_ack   = gr;
    m_idx   = gr ? m_tgt : 0;
    m_ev    = gr && m_tev;
    m_err   = free_valid && !pre[fi] && !same;
    if (free_valid && pre[fi] && !same) mv[fi] = 1'b0;
    if (gr) begin
      mv[m_tgt] = 1'b1;
      m_nf = (m_tgt + 1) % DEPTH;
    end
    case (m_mode)
      0: if (alloc_req) begin
           if (pre_cnt == DEPTH) begin
             m_mode = 2; m_tgt = int'(rnd) % DEPTH; m_tev = 1'b1;
           end else begin
             m_mode = 1; m_cur = m_nf;
           end
         end
      1: if (!pre[m_cur]) begin
           m_mode = 2; m_tgt = m_cur; m_tev = 1'b0;
         end else begin
           m_cur = (m_cur + 1) % DEPTH;
         end
      default: m_mode = 0;
    endcase
  endtask

  // Compare every cycle, 1 time unit after the active edge.
  always @(posedge clk) begin
    #1;
    check("cmp_count", 32'(count), 32'(m_popcnt()));
    check("cmp_full", 32'(full), 32'(m_popcnt() == DEPTH));
    check("cmp_empty", 32'(empty), 32'(m_popcnt() == 0));
    check("cmp_ack", 32'(alloc_ack), 32'(m_ack));
    check("cmp_idx", 32'(alloc_idx), 32'(m_idx));
    check("cmp_evict", 32'(alloc_evict), 32'(m_ev));
    check("cmp_free_err", 32'(free_err), 32'(m_err));
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    model_advance();
    @(negedge clk);
  endtask

  // Count edges from the first sampling edge until AllocAck is seen.
  task automatic wait_ack(input string tag, input int budget, output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (alloc_ack !== 1'b1 && lat < budget);
    if (alloc_ack !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: no AllocAck within %0d cycles", tag, budget);
    end
  endtask

  initial begin
    int lat;
    int free_pct;
    rst_n = 1'b0; rnd = '0; alloc_req = 1'b0; free_valid = 1'b0; free_idx = '0;
    tick();
    tick();
    check("rst_count", 32'(count), 32'd0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ack", 32'(alloc_ack), 32'd0);
    check("rst_idx", 32'(alloc_idx), 32'd0);

    // First grant after reset, request held.
    rst_n = 1'b1;
    alloc_req = 1'b1;
    wait_ack("first", 20, lat);
    check("first_lat", 32'(lat), 32'd3);
    check("first_idx", 32'(alloc_idx), 32'd0);
    check("first_evict", 32'(alloc_evict), 32'd0);
    check("first_count", 32'(count), 32'd1);
    check("first_empty", 32'(empty), 32'd0);

    // Keep holding: indices come out in order.
    for (int i = 1; i < DEPTH; i++) begin
      wait_ack("fill", 20, lat);
      check("fill_lat", 32'(lat), 32'd3);
      check("fill_idx", 32'(alloc_idx), 32'(i));
    end
    alloc_req = 1'b0;
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);

    // Release entry 5, then scan from 0 must skip 0..4.
    free_valid = 1'b1; free_idx = 4'd5;
    tick();
    free_valid = 1'b0;
    check("free5_count", 32'(count), 32'd15);
    check("free5_err", 32'(free_err), 32'd0);
    alloc_req = 1'b1;
    wait_ack("scan5", 40, lat);
    alloc_req = 1'b0;
    check("scan5_lat", 32'(lat), 32'd8);
    check("scan5_idx", 32'(alloc_idx), 32'd5);
    check("scan5_evict", 32'(alloc_evict), 32'd0);
    check("scan5_count", 32'(count), 32'd16);

    // Full CAM: random victim from the LFSR word.
    rnd = 16'hACA4;
    alloc_req = 1'b1;
    wait_ack("evict", 10, lat);
    alloc_req = 1'b0;
    rnd = 16'(($urandom));
    check("evict_lat", 32'(lat), 32'd2);
    check("evict_idx", 32'(alloc_idx), 32'd4);
    check("evict_flag", 32'(alloc_evict), 32'd1);
    check("evict_count", 32'(count), 32'd16);

    // Release entry 9, then free it again during its own GRANT cycle.
    free_valid = 1'b1; free_idx = 4'd9;
    tick();
    free_valid = 1'b0;
    alloc_req = 1'b1;
    for (int i = 0; i < 40 && m_mode != 2; i++) tick();
    free_valid = 1'b1; free_idx = 4'd9;
    tick();
    free_valid = 1'b0;
    alloc_req = 1'b0;
    check("race_ack", 32'(alloc_ack), 32'd1);
    check("race_idx", 32'(alloc_idx), 32'd9);
    check("race_err", 32'(free_err), 32'd0);
    check("race_count", 32'(count), 32'd16);
    tick();
    check("race_count2", 32'(count), 32'd16);

    // Reset in the middle of a long scan.
    free_valid = 1'b1; free_idx = 4'd3;
    tick();
    free_valid = 1'b0;
    alloc_req = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0; alloc_req = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("rstscan_ack", 32'(alloc_ack), 32'd0);
    end
    check("rstscan_count", 32'(count), 32'd0);
    check("rstscan_empty", 32'(empty), 32'd1);

    // Release of an invalid entry on an empty CAM.
    free_valid = 1'b1; free_idx = 4'd3;
    tick();
    free_valid = 1'b0;
    check("badfree_err", 32'(free_err), 32'd1);
    check("badfree_count", 32'(count), 32'd0);
    tick();
    check("badfree_pulse", 32'(free_err), 32'd0);

    alloc_req = 1'b1;
    wait_ack("post_rst", 20, lat);
    alloc_req = 1'b0;
    check("post_rst_lat", 32'(lat), 32'd3);
    check("post_rst_idx", 32'(alloc_idx), 32'd0);
    check("post_rst_count", 32'(count), 32'd1);

    // Randomized traffic, alternating fill-heavy and free-heavy windows.
    for (int c = 0; c < 4000; c++) begin
      free_pct = ((c / 400) % 2 == 0) ? 6 : 45;
      if (m_ack) alloc_req = 1'b0;
      else if (!alloc_req && $urandom_range(0, 3) == 0) alloc_req = 1'b1;
      rnd        = 16'($urandom);
      free_valid = ($urandom_range(0, 99) < free_pct);
      free_idx   = AW'($urandom_range(0, DEPTH - 1));
      rst_n      = ($urandom_range(0, 999) != 0);
      tick();
    end

    rst_n = 1'b1; alloc_req = 1'b0; free_valid = 1'b0;
    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
